// File: rtl/btb_array.sv
// Branch target buffer storage: 2-way set-associative array with per-set LRU,
// a single-entry update port driven by a pending-target holder, and a
// set-by-set flush sequencer.
module btb_array #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned NUM_WAYS = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        lookup_en_i,
  input  logic [9:0]  lookup_tag_i,
  input  logic [3:0]  lookup_set_i,
  output logic        hit_o,
  output logic [15:0] hit_target_o,
  input  logic        update_req_i,
  input  logic [9:0]  update_tag_i,
  input  logic [3:0]  update_set_i,
  input  logic [15:0] update_target_i,
  output logic        update_ack_o,
  input  logic        flush_i,
  output logic        busy_o
);

  localparam logic [3:0] LastSet = 4'(NUM_SETS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StFlush} state_e;

  state_e              state_q;
  logic [3:0]          flush_cnt_q;
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [9:0]          tag_q    [NUM_SETS][NUM_WAYS];
  logic [15:0]         target_q [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0] lru_q;

  logic [1:0] lk_match;
  logic [1:0] up_match;
  logic       hit_way;
  logic       wr_way;
  logic       do_write;

  // Tag compare for lookup and update ports, way choice and gated outputs.
  // Outputs are masked by reset so they read idle during the reset cycle too.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      lk_match[w] = valid_q[lookup_set_i][w] && (tag_q[lookup_set_i][w] == lookup_tag_i);
      up_match[w] = valid_q[update_set_i][w] && (tag_q[update_set_i][w] == update_tag_i);
    end

    // Way 0 wins when both ways match.
    hit_way      = ~lk_match[0];
    hit_o        = ~reset_i & lookup_en_i & (state_q != StFlush) & (|lk_match);
    hit_target_o = hit_o ? target_q[lookup_set_i][hit_way] : 16'h0000;

    if (up_match[0]) begin
      wr_way = 1'b0;
    end else if (up_match[1]) begin
      wr_way = 1'b1;
    end else if (!valid_q[update_set_i][0]) begin
      wr_way = 1'b0;
    end else if (!valid_q[update_set_i][1]) begin
      wr_way = 1'b1;
    end else begin
      wr_way = lru_q[update_set_i];
    end

    // A flush arriving in the write cycle cancels the write and its ack.
    do_write     = (state_q == StWrite) & ~flush_i & ~reset_i;
    update_ack_o = do_write;
    busy_o       = ~reset_i & (state_q == StFlush);
  end

  // Control FSM: idle, one-cycle write, 16-cycle flush walk.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
          end else if (update_req_i) begin
            state_q <= StWrite;
          end
        end
        StWrite: begin
          flush_cnt_q <= '0;
          state_q     <= flush_i ? StFlush : StIdle;
        end
        StFlush: begin
          flush_cnt_q <= flush_cnt_q + 4'd1;
          if (flush_cnt_q == LastSet) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Valid bits and LRU; a write's LRU update overrides a same-set hit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (state_q == StFlush) begin
        valid_q[flush_cnt_q] <= '0;
      end
      if (hit_o) begin
        lru_q[lookup_set_i] <= ~hit_way;
      end
      if (do_write) begin
        valid_q[update_set_i][wr_way] <= 1'b1;
        lru_q[update_set_i]           <= ~wr_way;
      end
    end
  end

  // Tag/target payload: no reset, flush leaves it alone; valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      tag_q[update_set_i][wr_way]    <= update_tag_i;
      target_q[update_set_i][wr_way] <= update_target_i;
    end
  end

endmodule

// File: tb/tb_btb_array.sv
// Scoreboard bench for btb_array: stimulus pushes expected lookup results, ack
// cycles and busy-run lengths; a negedge monitor pops and compares them.
module tb_btb_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_en;
  logic [9:0]  lookup_tag;
  logic [3:0]  lookup_set;
  logic        hit;
  logic [15:0] hit_target;
  logic        update_req;
  logic [9:0]  update_tag;
  logic [3:0]  update_set;
  logic [15:0] update_target;
  logic        update_ack;
  logic        flush;
  logic        busy;

  always #5 clk = ~clk;

  btb_array #(
    .NUM_SETS(16),
    .NUM_WAYS(2)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .lookup_en_i    (lookup_en),
    .lookup_tag_i   (lookup_tag),
    .lookup_set_i   (lookup_set),
    .hit_o          (hit),
    .hit_target_o   (hit_target),
    .update_req_i   (update_req),
    .update_tag_i   (update_tag),
    .update_set_i   (update_set),
    .update_target_i(update_target),
    .update_ack_o   (update_ack),
    .flush_i        (flush),
    .busy_o         (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        hit;
    logic [15:0] tgt;
  } lk_exp_t;

  lk_exp_t lk_q[$];
  int      ack_q[$];
  int      busy_q[$];
  int      n_checks = 0;
  int      n_pass = 0;
  int      busy_run = 0;
  lk_exp_t lk_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: compare every presented lookup, ack pulse and completed busy run.
  always @(negedge clk) begin
    if (lookup_en) begin
      if (lk_q.size() == 0) begin
        check("unexpected lookup", 32'd1, 32'd0);
      end else begin
        lk_e = lk_q.pop_front();
        check({lk_e.name, " hit"}, {31'd0, hit}, {31'd0, lk_e.hit});
        check({lk_e.name, " target"}, {16'd0, hit_target}, {16'd0, lk_e.tgt});
      end
    end
    if (update_ack) begin
      if (ack_q.size() == 0) check("unexpected ack", 32'(cyc), 32'hFFFF_FFFF);
      else check("ack cycle", 32'(cyc), 32'(ack_q.pop_front()));
    end
    if (busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      if (busy_q.size() == 0) check("unexpected busy run", 32'(busy_run), 32'd0);
      else check("busy length", 32'(busy_run), 32'(busy_q.pop_front()));
      busy_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string name, input logic [9:0] tag, input logic [3:0] set,
                        input logic eh, input logic [15:0] et);
    lk_q.push_back('{name, eh, et});
    lookup_tag = tag;
    lookup_set = set;
    lookup_en  = 1'b1;
    tick();
    lookup_en  = 1'b0;
  endtask

  task automatic start_update(input logic [9:0] tag, input logic [3:0] set,
                              input logic [15:0] tgt, input int lat);
    update_tag    = tag;
    update_set    = set;
    update_target = tgt;
    update_req    = 1'b1;
    ack_q.push_back(cyc + lat);
  endtask

  // Holder model: keep the request up until an ack is seen, then clear.
  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!update_ack && n < 60);
    if (!update_ack) check("ack timeout", 32'd0, 32'd1);
    tick();
    update_req = 1'b0;
  endtask

  task automatic install(input logic [9:0] tag, input logic [3:0] set, input logic [15:0] tgt);
    start_update(tag, set, tgt, 1);
    wait_ack();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; lookup_en = 1'b0; lookup_tag = '0; lookup_set = '0;
    update_req = 1'b0; update_tag = '0; update_set = '0; update_target = '0;
    flush = 1'b0;
    tick();
    tick();
    // Reset state: outputs idle even with a lookup presented.
    lookup("reset lookup", 10'h000, 4'd0, 1'b0, 16'h0000);
    check("busy in reset", {31'd0, busy}, 32'd0);
    check("ack in reset", {31'd0, update_ack}, 32'd0);
    reset = 1'b0;
    tick();
    lookup("empty set 3", 10'h12A, 4'd3, 1'b0, 16'h0000);

    // Fill and hit.
    install(10'h12A, 4'd3, 16'h3040);
    lookup("fill hit", 10'h12A, 4'd3, 1'b1, 16'h3040);
    check("lru[3] after fill", {31'd0, dut.lru_q[3]}, 32'd1);
    lookup("other set miss", 10'h12A, 4'd4, 1'b0, 16'h0000);
    lookup("other tag miss", 10'h12B, 4'd3, 1'b0, 16'h0000);

    // Replacement: hit on way 0 makes way 1 the victim.
    install(10'h001, 4'd5, 16'h5001);
    install(10'h002, 4'd5, 16'h5002);
    lookup("repl touch 001", 10'h001, 4'd5, 1'b1, 16'h5001);
    install(10'h003, 4'd5, 16'h5003);
    lookup("repl 002 evicted", 10'h002, 4'd5, 1'b0, 16'h0000);
    lookup("repl 001 kept", 10'h001, 4'd5, 1'b1, 16'h5001);
    lookup("repl 003 new", 10'h003, 4'd5, 1'b1, 16'h5003);

    // Same-tag update overwrites in place.
    install(10'h0AA, 4'd0, 16'h1000);
    install(10'h0AA, 4'd0, 16'h2000);
    check("set0 valid ways", {30'd0, dut.valid_q[0]}, 32'd1);
    lookup("same-tag target", 10'h0AA, 4'd0, 1'b1, 16'h2000);

    // Flush in the write cycle: no ack, 16 busy cycles, write after exit.
    start_update(10'h1FF, 4'd7, 16'h7777, 19);
    tick();
    flush = 1'b1;
    busy_q.push_back(16);
    tick();
    flush = 1'b0;
    lookup("hit gated in flush", 10'h003, 4'd5, 1'b0, 16'h0000);
    wait_ack();
    lookup("flushed 12A", 10'h12A, 4'd3, 1'b0, 16'h0000);
    lookup("flushed 001", 10'h001, 4'd5, 1'b0, 16'h0000);
    lookup("flushed 003", 10'h003, 4'd5, 1'b0, 16'h0000);
    lookup("flushed 0AA", 10'h0AA, 4'd0, 1'b0, 16'h0000);
    lookup("post-flush write", 10'h1FF, 4'd7, 1'b1, 16'h7777);

    // Reset in the write cycle discards it; request is re-serviced.
    start_update(10'h0D0, 4'd9, 16'h9090, 3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ack();
    lookup("post-reset write", 10'h0D0, 4'd9, 1'b1, 16'h9090);
    install(10'h0C0, 4'd12, 16'hC0C0);
    lookup("set12 before flush", 10'h0C0, 4'd12, 1'b1, 16'hC0C0);

    // Reset at flush cycle 7.
    flush = 1'b1;
    busy_q.push_back(7);
    tick();
    flush = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("busy after reset", {31'd0, busy}, 32'd0);
    lookup("reset-flush 0D0", 10'h0D0, 4'd9, 1'b0, 16'h0000);
    lookup("reset-flush 0C0", 10'h0C0, 4'd12, 1'b0, 16'h0000);
    install(10'h0E0, 4'd9, 16'hE0E0);
    lookup("idle after reset", 10'h0E0, 4'd9, 1'b1, 16'hE0E0);

    tick();
    tick();
    check("lookup queue drained", 32'(lk_q.size()), 32'd0);
    check("ack queue drained", 32'(ack_q.size()), 32'd0);
    check("busy queue drained", 32'(busy_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/btb_array.md
BTB_ARRAY -- requirements
Module: btb_array

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16, number of sets; index width is 4 bits (lc3b_set).
REQ-002 SHALL have parameter NUM_WAYS, default 2, associativity; only 2 is supported.
REQ-003 clk  input  1  sole clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 lookup_en  input  1  fetch lookup valid this cycle.
REQ-006 lookup_tag  input  10  fetch PC tag (lc3b_pc_tag).
REQ-007 lookup_set  input  4  fetch PC set (lc3b_set).
REQ-008 hit  output  1  lookup hit, combinational.
REQ-009 hit_target  output  16  predicted target (lc3b_word), combinational.
REQ-010 update_req  input  1  target holder has a pending entry; level, held until acked.
REQ-011 update_tag  input  10  tag to install.
REQ-012 update_set  input  4  set to install.
REQ-013 update_target  input  16  target to install.
REQ-014 update_ack  output  1  one-cycle pulse; drives the holder's clear.
REQ-015 flush  input  1  invalidate all entries.
REQ-016 busy  output  1  high while a flush is in progress.

Function
REQ-017 SHALL store per set and way: valid (1b), tag (10b), target (16b); plus one LRU bit per set naming the way to replace next.
REQ-018 hit SHALL be 1 iff lookup_en=1, state!=FLUSH, and some way in lookup_set is valid with tag==lookup_tag.
- If both ways match, way 0 wins.
REQ-019 hit_target SHALL be the matching way's target when hit=1, else 16'h0000.
- Lookups read pre-write array contents; no write bypass.
REQ-020 FSM states SHALL be IDLE, WRITE, FLUSH.
REQ-021 IDLE->WRITE SHALL occur when update_req=1 and flush=0.
REQ-022 In WRITE:
- update_ack=1 for exactly that cycle.
- At the closing edge, the entry is written and the state returns to IDLE.
- Minimum spacing between writes is 2 cycles.
REQ-023 Write-way selection, in priority order:
- A valid way in update_set with tag==update_tag: overwrite its target only.
- Else the first invalid way (way 0 before way 1).
- Else the way named by the LRU bit.
- The written way is marked valid.
REQ-024 On a write to way w, lru[update_set] SHALL become ~w.
REQ-025 On a hit in way w (not in FLUSH), lru[lookup_set] SHALL become ~w.
- If a write and a hit touch the same set in the same cycle, the write's LRU update wins.
REQ-026 flush=1 in IDLE or WRITE SHALL enter FLUSH at the next edge.
- A WRITE interrupted this way performs no write and no ack; the still-pending update_req is serviced after the flush.
REQ-027 In FLUSH:
- A 4-bit counter starts at 0 and clears both valid bits of set[counter] each cycle.
- After set 15 the state returns to IDLE, so FLUSH lasts exactly 16 cycles.
- busy=1 throughout; update_req and flush are ignored.
REQ-028 Tags and targets SHALL NOT be cleared by flush; only valid bits.

Reset
REQ-029 On reset=1 at posedge:
- State=IDLE, flush counter=0.
- All valid bits=0, all LRU bits=0.
- Tag and target contents are don't-care.
REQ-030 During and after reset: hit=0, hit_target=16'h0000, update_ack=0, busy=0.
REQ-031 Reset SHALL override any state, including mid-FLUSH and WRITE.
- An interrupted write is discarded and the pending request is re-serviced after reset deasserts.

Verification
REQ-032 Fill and hit:
- Stimulus: after reset, update_req with tag=0x12A, set=3, target=0x3040.
- Required: ack in the 2nd cycle; then lookup tag=0x12A, set=3 gives hit=1, hit_target=0x3040, and lru[3]=1.
REQ-033 Replacement:
- Stimulus: fill set 5 with tags 0x001 (way 0) and 0x002 (way 1); look up 0x001 (hit); install 0x003.
- Required: way 1 is replaced, so 0x002 misses and 0x001 and 0x003 both hit.
REQ-034 Same-tag update:
- Stimulus: install tag=0x0AA, set=0 with target 0x1000, then the same tag/set with target 0x2000.
- Required: only one way is valid in set 0; lookup returns 0x2000.
REQ-035 Flush during write:
- Stimulus: update_req; flush asserted in the WRITE cycle.
- Required: no ack; busy=1 for 16 cycles; hit=0 for all prior entries; the pending entry is written with ack in the 2nd cycle after FLUSH exits.
REQ-036 Reset mid-flush:
- Stimulus: reset at flush cycle 7.
- Required: busy=0 next cycle, state IDLE, all lookups miss.
